adg408_tx_sequencer: RTL
========================

Name: adg408_tx_sequencer

Overview:
Transmit-side channel sequencer for the ADG408 excitation multiplexer. It is the counterpart of the receive-side ADG408 address stepper.
- For each transmit channel in turn it selects the mux address, waits for settling and fires an excitation pulse.
- It then hands the receive start channel to the receive sequencer (start_state / start_state_en) and waits for that side's "all 7 receive channels done" pulse.
- After the last transmit channel it flags frame completion.

Parameters:
- NUM_TX_CH, 7: transmit channels per frame (addresses 0..NUM_TX_CH-1). Legal range 1..8.
- SETTLE_CYC, 16: clks cycles the mux address is held before the pulse. Minimum 1.
- PULSE_CYC, 8: width of tx_pulse in clks cycles. Minimum 1.
- RX_TIMEOUT, 65535: maximum cycles to wait for rx_all_done before giving up on the channel. Minimum 1.

Ports:
- clks, in, 1: system clock. All logic is on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- scan_start, in, 1: single-cycle pulse that starts a frame. Ignored while busy=1.
- scan_abort, in, 1: level or pulse. Aborts the frame immediately.
- rx_all_done, in, 1: single-cycle pulse from the receive sequencer when its 7-channel cycle is complete.
- tx_addr, out, 3: ADG408 A2..A0 address for the transmit mux.
- tx_en, out, 1: ADG408 EN. High only while a channel is selected.
- tx_pulse, out, 1: excitation strobe.
- start_state, out, 3: receive start channel handed to the receive sequencer.
- start_state_en, out, 1: single-cycle qualifier for start_state.
- busy, out, 1: high from the cycle after an accepted scan_start until the return to IDLE.
- cur_ch, out, 3: current transmit channel index.
- frame_done, out, 1: single-cycle pulse at the end of a complete frame.
- timeout_err, out, 1: sticky. Set on any receive timeout. Cleared by the next accepted scan_start.

Behaviour:
- Reset values: all outputs are 0. FSM is in IDLE, and all counters are 0.
- FSM states: IDLE, SETTLE, PULSE, HANDOFF, WAIT_RX, DONE.
- IDLE:
  - scan_start=1 -> SETTLE next cycle, with cur_ch=0, tx_addr=0, tx_en=1, busy=1 and timeout_err cleared.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles, then -> PULSE.
- PULSE:
  - tx_pulse=1 for exactly PULSE_CYC cycles, then -> HANDOFF.
- HANDOFF:
  - Lasts one cycle, with start_state_en=1 and start_state=(cur_ch+1) mod NUM_TX_CH.
  - Then -> WAIT_RX.
  - start_state holds its value until the next HANDOFF.
- WAIT_RX:
  - The wait counter counts from 0.
  - On rx_all_done=1: if cur_ch==NUM_TX_CH-1 -> DONE; otherwise cur_ch+1 and -> SETTLE, with tx_addr updated in the same cycle as the state change.
  - If the counter reaches RX_TIMEOUT-1 with no rx_all_done: set timeout_err and advance exactly as if rx_all_done had arrived.
  - rx_all_done on the timeout cycle is treated as a normal completion, and timeout_err is not set.
- DONE:
  - Lasts one cycle, with frame_done=1, tx_en=0 and busy=0 on exit.
  - Then -> IDLE.
- Latency: accepted scan_start at cycle 0 gives tx_en=1 at cycle 1, first tx_pulse at cycle SETTLE_CYC+1, and start_state_en at cycle SETTLE_CYC+PULSE_CYC+1.
- tx_en stays high across channel changes within a frame. It is low in IDLE and DONE.
- Ignored inputs:
  - rx_all_done outside WAIT_RX is ignored and not remembered.
  - scan_start while busy is ignored.
- scan_abort has priority over every other input in every state except IDLE:
  - Next cycle the FSM is in IDLE.
  - tx_en, tx_pulse, start_state_en and busy go to 0.
  - No frame_done is generated. timeout_err keeps its value.
- Counters:
  - Width is clog2 of the largest of SETTLE_CYC, PULSE_CYC and RX_TIMEOUT. No wrap occurs inside a state.
  - cur_ch arithmetic is 3-bit. The start_state modulo uses NUM_TX_CH, not 8.
- Reset mid-frame: immediate return to reset values, with no pulse glitch beyond asynchronous deassertion.

Decomposition:
- Shared package adg408_pkg holds:
  - the state enum;
  - ADG408 address constants CH0..CH7 = 3'd0..3'd7;
  - the NUM_RX_CH=7 constant, shared with the receive sequencer.
- One natural sub-module, adg408_cycle_timer: a loadable down-counter with a one-cycle expiry flag. It is reused for the settle, pulse and timeout intervals.

Test Plan (SETTLE_CYC=4, PULSE_CYC=2, NUM_TX_CH=7, RX_TIMEOUT=100):
- scan_start at cycle 0 -> tx_en=1 and tx_addr=0 at cycle 1; tx_pulse high at cycles 5-6; start_state_en at cycle 7 with start_state=1.
- Full frame with rx_all_done 10 cycles after each handoff -> tx_addr steps 0..6; start_state sequence 1,2,3,4,5,6,0; exactly one frame_done pulse; busy low afterwards; timeout_err=0.
- No rx_all_done on channel 2 -> 100 cycles after its handoff, channel 3 is selected and timeout_err=1. The frame still completes and frame_done fires.
- scan_abort during PULSE of channel 4 -> next cycle tx_en=0, tx_pulse=0, busy=0; no frame_done. A new scan_start restarts at tx_addr=0.
- rx_all_done during SETTLE and a second scan_start while busy -> both are ignored, and channel timing is unchanged.
- rst_n low during WAIT_RX of channel 5 -> all outputs are 0 immediately. After release, scan_start begins at channel 0.

Source files
------------

// File: rtl/adg408_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adg408_pkg
// Brief   : Shared types and constants for the ADG408 tx/rx channel sequencers
// Revision: 1.0 - initial release
// ============================================================================
package adg408_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_WAIT_RX = 3'd4,
        ST_DONE    = 3'd5
    } adg408_state_e;

    localparam logic [2:0] CH0 = 3'd0;
    localparam logic [2:0] CH1 = 3'd1;
    localparam logic [2:0] CH2 = 3'd2;
    localparam logic [2:0] CH3 = 3'd3;
    localparam logic [2:0] CH4 = 3'd4;
    localparam logic [2:0] CH5 = 3'd5;
    localparam logic [2:0] CH6 = 3'd6;
    localparam logic [2:0] CH7 = 3'd7;

    localparam int NUM_RX_CH = 7;

    // Receive start channel for transmit channel ch, wrapping at the frame length
    function automatic logic [2:0] next_start_ch(input logic [2:0] ch, input logic [2:0] last_ch);
        return (ch >= last_ch) ? CH0 : ch + 3'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adg408_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : adg408_tx_sequencer_if
// Brief   : Control, mux and receive-handoff signals of the tx sequencer
// Revision: 1.0 - initial release
// ============================================================================
interface adg408_tx_sequencer_if;

    logic       scan_start;
    logic       scan_abort;
    logic       rx_all_done;
    logic [2:0] tx_addr;
    logic       tx_en;
    logic       tx_pulse;
    logic [2:0] start_state;
    logic       start_state_en;
    logic       busy;
    logic [2:0] cur_ch;
    logic       frame_done;
    logic       timeout_err;

    // Host / receive-sequencer side
    modport master (
        output scan_start, scan_abort, rx_all_done,
        input  tx_addr, tx_en, tx_pulse, start_state, start_state_en,
        input  busy, cur_ch, frame_done, timeout_err
    );

    // Sequencer side
    modport slave (
        input  scan_start, scan_abort, rx_all_done,
        output tx_addr, tx_en, tx_pulse, start_state, start_state_en,
        output busy, cur_ch, frame_done, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/adg408_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module  : adg408_cycle_timer
// Brief   : Loadable down-counter; o_expired pulses in the last loaded cycle
// Revision: 1.0 - initial release
// ============================================================================
module adg408_cycle_timer #(
    parameter int WIDTH = 16
) (
    input  wire logic             clks,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_expired
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_run;

    // Loading N-1 gives an interval of exactly N cycles, expiry in the last one
    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_expired = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/adg408_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : adg408_tx_sequencer
// Brief   : Steps the ADG408 transmit mux, fires excitation pulses and hands
//           each channel over to the receive sequencer
// Revision: 1.0 - initial release
// ============================================================================
module adg408_tx_sequencer #(
    parameter int NUM_TX_CH  = 7,
    parameter int SETTLE_CYC = 16,
    parameter int PULSE_CYC  = 8,
    parameter int RX_TIMEOUT = 65535
) (
    input  wire logic         clks,
    input  wire logic         rst_n,
    adg408_tx_sequencer_if.slave bus
);

    import adg408_pkg::*;

    localparam int c_MAX_CYC = max3(SETTLE_CYC, PULSE_CYC, RX_TIMEOUT);
    localparam int c_CW      = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CW-1:0] c_SETTLE_LD = c_CW'(SETTLE_CYC - 1);
    localparam logic [c_CW-1:0] c_PULSE_LD  = c_CW'(PULSE_CYC - 1);
    localparam logic [c_CW-1:0] c_RX_LD     = c_CW'(RX_TIMEOUT - 1);
    localparam logic [2:0]      c_LAST_CH   = 3'(NUM_TX_CH - 1);

    localparam logic [2:0] c_S_IDLE    = ST_IDLE;
    localparam logic [2:0] c_S_SETTLE  = ST_SETTLE;
    localparam logic [2:0] c_S_PULSE   = ST_PULSE;
    localparam logic [2:0] c_S_HANDOFF = ST_HANDOFF;
    localparam logic [2:0] c_S_WAIT_RX = ST_WAIT_RX;
    localparam logic [2:0] c_S_DONE    = ST_DONE;

    logic [2:0]      r_state;
    logic [2:0]      r_cur_ch;
    logic [2:0]      r_start_state;
    logic            r_start_state_en;
    logic            r_tx_en;
    logic            r_tx_pulse;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_timeout_err;

    logic            w_abort;
    logic            w_load;
    logic [c_CW-1:0] w_load_val;
    logic            w_expired;

    // One shared timer: reloaded on every entry into a timed state
    always_comb begin
        w_abort    = bus.scan_abort && (r_state != c_S_IDLE);
        w_load     = 1'b0;
        w_load_val = c_SETTLE_LD;
        if (!w_abort) begin
            case (r_state)
                c_S_IDLE:    w_load = bus.scan_start;
                c_S_SETTLE: begin
                    w_load     = w_expired;
                    w_load_val = c_PULSE_LD;
                end
                c_S_HANDOFF: begin
                    w_load     = 1'b1;
                    w_load_val = c_RX_LD;
                end
                c_S_WAIT_RX: w_load = bus.rx_all_done || w_expired;
                default:     w_load = 1'b0;
            endcase
        end
    end

    adg408_cycle_timer #(
        .WIDTH (c_CW)
    ) u_timer (
        .clks       (clks),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_clear    (w_abort),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_S_IDLE;
            r_cur_ch         <= CH0;
            r_start_state    <= CH0;
            r_start_state_en <= 1'b0;
            r_tx_en          <= 1'b0;
            r_tx_pulse       <= 1'b0;
            r_busy           <= 1'b0;
            r_frame_done     <= 1'b0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_start_state_en <= 1'b0;
            r_frame_done     <= 1'b0;
            if (w_abort) begin
                r_state    <= c_S_IDLE;
                r_tx_en    <= 1'b0;
                r_tx_pulse <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (bus.scan_start) begin
                            r_state       <= c_S_SETTLE;
                            r_cur_ch      <= CH0;
                            r_tx_en       <= 1'b1;
                            r_busy        <= 1'b1;
                            r_timeout_err <= 1'b0;
                        end
                    end
                    c_S_SETTLE: begin
                        if (w_expired) begin
                            r_state    <= c_S_PULSE;
                            r_tx_pulse <= 1'b1;
                        end
                    end
                    c_S_PULSE: begin
                        if (w_expired) begin
                            r_state          <= c_S_HANDOFF;
                            r_tx_pulse       <= 1'b0;
                            r_start_state_en <= 1'b1;
                            r_start_state    <= next_start_ch(r_cur_ch, c_LAST_CH);
                        end
                    end
                    c_S_HANDOFF: r_state <= c_S_WAIT_RX;
                    c_S_WAIT_RX: begin
                        // A completion in the expiry cycle wins over the timeout
                        if (bus.rx_all_done || w_expired) begin
                            if (!bus.rx_all_done) begin
                                r_timeout_err <= 1'b1;
                            end
                            if (r_cur_ch == c_LAST_CH) begin
                                r_state      <= c_S_DONE;
                                r_tx_en      <= 1'b0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state  <= c_S_SETTLE;
                                r_cur_ch <= r_cur_ch + 3'd1;
                            end
                        end
                    end
                    c_S_DONE: begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state    <= c_S_IDLE;
                        r_tx_en    <= 1'b0;
                        r_tx_pulse <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tx_addr        = r_cur_ch;
    assign bus.cur_ch         = r_cur_ch;
    assign bus.tx_en          = r_tx_en;
    assign bus.tx_pulse       = r_tx_pulse;
    assign bus.start_state    = r_start_state;
    assign bus.start_state_en = r_start_state_en;
    assign bus.busy           = r_busy;
    assign bus.frame_done     = r_frame_done;
    assign bus.timeout_err    = r_timeout_err;

endmodule
`default_nettype wire
